// File: rtl/mmio_gpio_responder.sv
// MMIO responder: LED register, synchronized/debounced switches and sticky rising-edge capture.
// Define MMIO_GPIO_SW_IRQ_EN to add the IRQMASK register (+0x18) and the registered o_irq output.
module mmio_gpio_responder #(
    parameter int unsigned  N          = 64,
    parameter logic [N-1:0] BASE_ADDR  = 'h8000,
    parameter int unsigned  DEB_CYCLES = 20000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_addr,
    input  logic [N-1:0] i_wdata,
    input  logic         i_we,
    input  logic         i_re,
    input  logic [15:0]  i_sw_in,
    output logic [N-1:0] o_rdata,
    output logic         o_hit,
`ifdef MMIO_GPIO_SW_IRQ_EN
    output logic         o_irq,
`endif
    output logic [15:0]  o_led
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [N-1:0] A_LED  = BASE_ADDR;
    localparam logic [N-1:0] A_SW   = BASE_ADDR + N'(8);
    localparam logic [N-1:0] A_EDGE = BASE_ADDR + N'(16);

    logic [15:0]   r_led;
    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;
    logic [15:0]   r_stable;
    logic [15:0]   r_edge;
    logic [CW-1:0] r_cnt;

    logic          w_aligned;
    logic          w_sel_led;
    logic          w_sel_sw;
    logic          w_sel_edge;
    logic          w_changed;
    logic          w_accept;
    logic [15:0]   w_rise;
    logic [15:0]   w_clr;
    logic [15:0]   w_rd16;
    logic          w_unused;

    assign w_aligned  = (i_addr[2:0] == 3'b000);
    assign w_sel_led  = w_aligned && (i_addr == A_LED);
    assign w_sel_sw   = w_aligned && (i_addr == A_SW);
    assign w_sel_edge = w_aligned && (i_addr == A_EDGE);

`ifdef MMIO_GPIO_SW_IRQ_EN
    localparam logic [N-1:0] A_MASK = BASE_ADDR + N'(24);

    logic [15:0] r_mask;
    logic        r_irq;
    logic        w_sel_mask;

    assign w_sel_mask = w_aligned && (i_addr == A_MASK);
    assign o_hit      = w_sel_led || w_sel_sw || w_sel_edge || w_sel_mask;
    assign o_irq      = r_irq;

    // Registered from current state, so it drops one cycle after a W1C or mask write.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (i_we && w_sel_mask) r_mask <= i_wdata[15:0];
            r_irq <= |(r_edge & r_mask);
        end
    end
`else
    assign o_hit = w_sel_led || w_sel_sw || w_sel_edge;
`endif

    always_comb begin
        w_rd16 = '0;
        if (w_sel_led)       w_rd16 = r_led;
        else if (w_sel_sw)   w_rd16 = r_stable;
        else if (w_sel_edge) w_rd16 = r_edge;
`ifdef MMIO_GPIO_SW_IRQ_EN
        else if (w_sel_mask) w_rd16 = r_mask;
`endif
        o_rdata = '0;
        if (i_re && o_hit) o_rdata = N'(w_rd16);
    end

    // Whole-vector debounce: the count survives changes of sync2 and only resets once it matches.
    assign w_changed = (r_sync2 != r_stable);
    assign w_accept  = w_changed && (r_cnt == CNT_LAST);
    assign w_rise    = w_accept ? (r_sync2 & ~r_stable) : 16'h0000;
    assign w_clr     = (i_we && w_sel_edge) ? i_wdata[15:0] : 16'h0000;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_led    <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_edge   <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_sw_in;
            r_sync2 <= r_sync1;
            if (!w_changed) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_edge <= (r_edge & ~w_clr) | w_rise;
            if (i_we && w_sel_led) r_led <= i_wdata[15:0];
        end
    end

    assign o_led    = r_led;
    assign w_unused = ^i_wdata[N-1:16];

endmodule

// File: tb/tb_mmio_gpio_responder.sv
// Directed bench for mmio_gpio_responder (DEB_CYCLES = 8) with a register-map model checked
// every cycle; define MMIO_GPIO_SW_IRQ_EN to also exercise IRQMASK and the interrupt.
module tb_mmio_gpio_responder;

    localparam int unsigned N    = 64;
    localparam int unsigned DEB  = 8;
    localparam logic [63:0] BASE = 64'h8000;
`ifdef MMIO_GPIO_SW_IRQ_EN
    localparam int NREGS = 4;
`else
    localparam int NREGS = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  addr;
    logic [N-1:0]  wdata;
    logic          we;
    logic          re;
    logic [15:0]   sw;
    logic [N-1:0]  rdata;
    logic          hit;
    logic [15:0]   led;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mmio_gpio_responder #(
        .N          (N),
        .BASE_ADDR  (BASE),
        .DEB_CYCLES (DEB)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_addr  (addr),
        .i_wdata (wdata),
        .i_we    (we),
        .i_re    (re),
        .i_sw_in (sw),
        .o_rdata (rdata),
        .o_hit   (hit),
`ifdef MMIO_GPIO_SW_IRQ_EN
        .o_irq   (irq),
`endif
        .o_led   (led)
    );

`ifndef MMIO_GPIO_SW_IRQ_EN
    assign irq = 1'b0;
`endif

    // Model: register file indexed by offset/8 (0 LED, 1 SW, 2 EDGE, 3 IRQMASK),
    // a two-deep history of sw for the synchronizer, and a stability counter.
    logic [15:0] m_reg [4];
    logic [15:0] m_hist [2];
    int          m_cnt;
    logic        m_irq;
    bit          m_valid = 0;

    function automatic int m_index(input logic [63:0] a);
        logic [63:0] off;
        if (a < BASE) return -1;
        off = a - BASE;
        if (off[2:0] != 3'b000) return -1;
        if (off >= 64'(8 * NREGS)) return -1;
        return int'(off >> 3);
    endfunction

    function automatic logic [63:0] m_rdata(input logic [63:0] a, input logic r);
        int idx;
        idx = m_index(a);
        if (!r || idx < 0) return 64'h0;
        return {48'h0, m_reg[idx]};
    endfunction

    task automatic model_step();
        logic [15:0] rise;
        logic [15:0] clr;
        int          idx;
        if (!rst_n) begin
            m_reg   = '{default: 16'h0};
            m_hist  = '{default: 16'h0};
            m_cnt   = 0;
            m_irq   = 1'b0;
            m_valid = 1;
        end else begin
            idx   = m_index(addr);
            m_irq = |(m_reg[2] & m_reg[3]);
            rise  = 16'h0;
            if (m_hist[1] == m_reg[1]) begin
                m_cnt = 0;
            end else if (m_cnt == DEB - 1) begin
                rise     = m_hist[1] & ~m_reg[1];
                m_reg[1] = m_hist[1];
                m_cnt    = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            clr      = (we && idx == 2) ? wdata[15:0] : 16'h0;
            m_reg[2] = (m_reg[2] & ~clr) | rise;
            if (we && idx == 0) m_reg[0] = wdata[15:0];
            if (we && idx == 3) m_reg[3] = wdata[15:0];
            m_hist[1] = m_hist[0];
            m_hist[0] = sw;
        end
    endtask

    always @(posedge clk) model_step();

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc hit", 64'(hit), (m_index(addr) >= 0) ? 64'h1 : 64'h0);
            check("cyc rdata", rdata, m_rdata(addr, re));
            check("cyc led", 64'(led), 64'(m_reg[0]));
`ifdef MMIO_GPIO_SW_IRQ_EN
            check("cyc irq", 64'(irq), 64'(m_irq));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic load(input string name, input logic [63:0] a, input logic [63:0] exp_rd,
                        input logic exp_hit);
        addr = a;
        re   = 1'b1;
        #1;
        check({name, " rdata"}, rdata, exp_rd);
        check({name, " hit"}, 64'(hit), 64'(exp_hit));
        re   = 1'b0;
        addr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        we    = 1'b0;
        re    = 1'b0;
        sw    = 16'h0;
        tick(2);
        rst_n = 1'b1;
        #1;
        check("reset led", 64'(led), 64'h0);
        load("reset sw", BASE + 64'h08, 64'h0, 1'b1);
        load("reset edge", BASE + 64'h10, 64'h0, 1'b1);

        store(BASE, 64'hFFFF_0000_0000_A5C3);
        check("led store", 64'(led), 64'hA5C3);
        load("led load", BASE, 64'h0000_0000_0000_A5C3, 1'b1);

        // Clean change: SW updates on the 10th edge after sw_in changes.
        sw = 16'h0005;
        tick(9);
        load("deb cyc9", BASE + 64'h08, 64'h0, 1'b1);
        tick(1);
        load("deb cyc10", BASE + 64'h08, 64'h5, 1'b1);
        load("deb edge", BASE + 64'h10, 64'h5, 1'b1);

        store(BASE + 64'h10, 64'h1);
        load("w1c", BASE + 64'h10, 64'h4, 1'b1);

        // Falling bit 0 is not captured; then its rise collides with a W1C of bit 0.
        sw = 16'h0004;
        tick(12);
        load("fall", BASE + 64'h10, 64'h4, 1'b1);
        sw = 16'h0005;
        tick(9);
        store(BASE + 64'h10, 64'h1);
        load("set wins", BASE + 64'h10, 64'h5, 1'b1);

        sw = 16'h0000;
        tick(12);
        store(BASE + 64'h10, 64'hFFFF);
        for (int i = 0; i < 40; i++) begin
            sw = (((i / 3) % 2) == 0) ? 16'h0001 : 16'h0000;
            tick(1);
        end
        tick(12);
        load("bounce sw", BASE + 64'h08, 64'h0, 1'b1);
        load("bounce edge", BASE + 64'h10, 64'h0, 1'b1);

        load("dec 8020", 64'h8020, 64'h0, 1'b0);
        tick(1);
        load("dec 8004", 64'h8004, 64'h0, 1'b0);
        tick(1);
        load("dec 10000", 64'h10000, 64'h0, 1'b0);
        tick(1);
`ifndef MMIO_GPIO_SW_IRQ_EN
        load("dec 8018", 64'h8018, 64'h0, 1'b0);
        tick(1);
`endif
        store(BASE + 64'h08, 64'hFFFF);
        load("sw store", BASE + 64'h08, 64'h0, 1'b1);
        addr = BASE;
        #1;
        check("re0 rdata", rdata, 64'h0);
        check("re0 hit", 64'(hit), 64'h1);
        addr = '0;

        // Reset mid-count discards it; a switch high out of reset is a rising edge.
        sw = 16'h0008;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        #1;
        check("rst led", 64'(led), 64'h0);
        tick(9);
        load("rst cyc9", BASE + 64'h08, 64'h0, 1'b1);
        tick(1);
        load("rst cyc10", BASE + 64'h08, 64'h8, 1'b1);
        load("rst edge", BASE + 64'h10, 64'h8, 1'b1);

`ifdef MMIO_GPIO_SW_IRQ_EN
        store(BASE + 64'h18, 64'h4);
        store(BASE + 64'h10, 64'hFFFF);
        load("mask", BASE + 64'h18, 64'h4, 1'b1);
        sw = 16'h000C;
        tick(10);
        load("irq edge", BASE + 64'h10, 64'h4, 1'b1);
        check("irq lag", 64'(irq), 64'h0);
        tick(1);
        check("irq set", 64'(irq), 64'h1);
        store(BASE + 64'h10, 64'h4);
        check("irq hold", 64'(irq), 64'h1);
        tick(1);
        check("irq clr", 64'(irq), 64'h0);
        sw = 16'h000D;
        tick(12);
        check("irq masked", 64'(irq), 64'h0);
        load("irq edge0", BASE + 64'h10, 64'h1, 1'b1);
`endif

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_gpio_responder.md
Name: mmio_gpio_responder

Overview:
- Memory-mapped I/O responder on the processor data-memory bus.
- Decodes DM_addr, DM_writeData, DM_writeEnable and DM_readEnable.
- Owns the LED output register, a synchronized and debounced switch input, and a sticky rising-edge capture register.
- Sits beside dmem on the divided clock; the top level selects its rdata over dmem readData when hit is high.

Parameters:
- N, 64: bus data and address width.
- BASE_ADDR, 64'h8000: address of the first register; all registers are 8-byte aligned.
- DEB_CYCLES, 20000: number of consecutive cycles a changed switch vector must hold stable before it is accepted; minimum 2.

Ports:
- clk  input  1  system clock (divided processor clock)
- reset  input  1  synchronous, active-low reset
- addr  input  N  data-memory address from datapath
- wdata  input  N  store data
- we  input  1  store strobe (DM_writeEnable)
- re  input  1  load strobe (DM_readEnable)
- sw_in  input  16  raw asynchronous board switches
- rdata  output  N  load data, combinational
- hit  output  1  addr decodes to a mapped register, combinational
- led  output  16  LED register contents
- irq  output  1  edge interrupt; present only with SW_IRQ_EN

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0x00 LED: read/write. Stores take wdata[15:0]; upper bits are ignored.
  - +0x08 SW: read-only. Returns the debounced switch vector, zero-extended.
  - +0x10 EDGE: read, write-1-to-clear. One sticky bit per switch.
  - +0x18 IRQMASK: only with SW_IRQ_EN; otherwise unmapped.
- Decode:
  - Full N-bit compare of addr against each register address; no aliasing.
  - addr[2:0] must be 0.
  - hit is high only for mapped addresses, independent of re and we.
- Read:
  - rdata = selected register, zero-extended, when re and hit are both high.
  - rdata = 0 otherwise.
  - Zero wait states, because the pipeline samples rdata in the same cycle.
- Write: takes effect at the clk edge where we and hit are both high. Writes to SW or to unmapped addresses are ignored.
- Synchronizer: sw_in passes through a 2-flop synchronizer (sync1, sync2).
- Debounce, whole-vector, one counter of width clog2(DEB_CYCLES):
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEB_CYCLES-1: stable <= sync2, counter <= 0.
  - Otherwise: counter increments.
  - A change in sync2 while counting does not restart the count; the value accepted is sync2 at the accepting edge.
  - Latency from a clean switch change to the SW register updating is DEB_CYCLES + 2 cycles.
- Edge capture:
  - rise = new_stable & ~stable, evaluated on the accepting edge.
  - edge <= (edge & ~clr) | rise, where clr = wdata[15:0] when an EDGE write occurs, else 0.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Falling edges are not captured.
- Reset (reset == 0 at a clk edge):
  - led = 0, stable = 0, edge = 0, counter = 0, sync1 = sync2 = 0, irqmask = 0.
  - Reset asserted mid-debounce discards the count.
  - After reset, switches already high at power-up are accepted after DEB_CYCLES + 2 cycles and register as rising edges.
- A store and a load are never both high in the same cycle; if they are, the write still occurs and rdata shows the pre-write value.

Optional Feature:
- Macro MMIO_GPIO_SW_IRQ_EN.
- Defined:
  - IRQMASK register at +0x18, read/write, bits [15:0].
  - irq port exists and is registered: irq <= |(edge & irqmask) each cycle, so it deasserts one cycle after the W1C or mask write.
  - Reset value of irq is 0.
- Undefined:
  - No IRQMASK register, no irq port, no interrupt logic.
  - addr 0x8018 gives hit = 0.

Test Plan:
- Reset then LED store: reset low for 2 cycles; store wdata=64'hFFFF_0000_0000_A5C3 to 0x8000 → led = 16'hA5C3. Load from 0x8000 → rdata = 64'h000000000000A5C3, hit = 1.
- Debounce accept (DEB_CYCLES=8): sw_in 0→16'h0005 held → load 0x8008 returns 0 at cycle 9 and 64'h5 at cycle 10. Load 0x8010 → 64'h5.
- Bounce rejection (DEB_CYCLES=8): sw_in toggles 0x0001/0x0000 every 3 cycles for 40 cycles and ends at 0 → SW stays 0 and EDGE stays 0.
- W1C and set-wins: EDGE = 0x0005; store 0x0001 to 0x8010 → EDGE = 0x0004. With an accepted bit-0 rise in the same cycle as a 0x0001 W1C → EDGE bit 0 remains 1.
- Decode boundaries: load 0x8020, 0x8004 and 0x10000 → hit = 0, rdata = 0. Store to 0x8008 → SW unchanged. re = 0 at 0x8000 → rdata = 0.
- Interrupt (MMIO_GPIO_SW_IRQ_EN): IRQMASK = 0x0004; accept a rise on bit 2 → irq = 1 one cycle after EDGE sets. W1C 0x0004 → irq = 0 the following cycle. Rise on bit 0 only → irq stays 0.
